// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Constants and types shared by the binary conv / pool pipeline.
//   CONV_W_L1 : conv output width of layer 1 (26)
//   CONV_W_L2 : conv output width of layer 2 (24)
//   SUM_W     : width of the signed conv partial sum (5)
//   pool_state_t : frame-control FSM states for the pooling stage
// -----------------------------------------------------------------------------
package bnn_pkg;

    localparam int CONV_W_L1 = 26;
    localparam int CONV_W_L2 = 24;
    localparam int SUM_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pool_state_t;

endpackage

// File: rtl/pool_line_buf.sv
// -----------------------------------------------------------------------------
// pool_line_buf
// One-bit-per-entry line buffer holding the horizontally OR-ed pairs of an
// even conv row until the matching odd row arrives.
//   clk   in  clock
//   we    in  write enable (synchronous write)
//   widx  in  write index
//   wdata in  write data
//   ridx  in  read index (combinational read)
//   rdata out read data
// Contents are not reset: every entry is written on an even row before the
// following odd row reads it.
// -----------------------------------------------------------------------------
module pool_line_buf #(
    parameter int DEPTH = 13,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic             wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic             rdata
);

    logic [DEPTH-1:0] cell_bits;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic cell_reg;

            always_ff @(posedge clk) begin
                if (we && (widx == IDX_W'(gi))) begin
                    cell_reg <= wdata;
                end
            end

            assign cell_bits[gi] = cell_reg;
        end
    endgenerate

    always_comb begin
        rdata = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = cell_bits[i];
            end
        end
    end

endmodule

// File: rtl/bin_pool2x2.sv
// -----------------------------------------------------------------------------
// bin_pool2x2
// Thresholds each signed conv sum to one bit and OR-reduces every
// non-overlapping 2x2 window (binary max-pool), emitting one pooled bit per
// window in row-major order. Layer geometry (26x26 or 24x24 input) is chosen
// by `state` when a frame starts.
//   clk     in  clock
//   rstn    in  asynchronous active-low reset
//   start   in  frame enable (level); low returns to IDLE and clears counters
//   state   in  layer select: 0 -> 26x26, 1 -> 24x24
//   din     in  signed conv sum
//   ivalid  in  din valid
//   up_done in  upstream conv-done pulse
//   dout    out pooled bit (held between beats)
//   ovalid  out one-cycle pulse when dout is new
//   olast   out pulse with the final pooled ovalid of the frame
//   done    out one-cycle pulse one cycle after olast
//   err     out sticky: up_done seen in RUN before the frame completed
// -----------------------------------------------------------------------------
module bin_pool2x2
    import bnn_pkg::*;
#(
    parameter logic signed [SUM_W-1:0] THRESH = 5'sd0,
    parameter int                      W_MAX  = 26
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             state,
    input  logic [SUM_W-1:0] din,
    input  logic             ivalid,
    input  logic             up_done,
    output logic             dout,
    output logic             ovalid,
    output logic             olast,
    output logic             done,
    output logic             err
);

    localparam int DEPTH = W_MAX / 2;
    localparam int CNT_W = $clog2(W_MAX);
    localparam int IDX_W = $clog2(DEPTH);

    pool_state_t fsm_reg, fsm_next;

    logic [CNT_W-1:0] wc_reg;
    logic [CNT_W-1:0] col_reg;
    logic [CNT_W-1:0] row_reg;
    logic             pair_reg;
    logic             dout_reg;
    logic             ovalid_reg;
    logic             olast_reg;
    logic             done_reg;
    logic             err_reg;

    logic signed [SUM_W-1:0] din_s;
    logic [CNT_W-1:0]        wc_m1;
    logic                    beat;
    logic                    col_end;
    logic                    last_beat;
    logic                    pix_bit;
    logic                    h_bit;
    logic [IDX_W-1:0]        lb_idx;
    logic                    lb_we;
    logic                    lb_rd;

    assign din_s     = din;
    assign wc_m1     = wc_reg - CNT_W'(1);
    assign beat      = (fsm_reg == RUN) && ivalid;
    assign col_end   = (col_reg == wc_m1);
    assign last_beat = beat && col_end && (row_reg == wc_m1);
    assign pix_bit   = (din_s >= THRESH);
    assign h_bit     = pair_reg | pix_bit;
    assign lb_idx    = IDX_W'(col_reg >> 1);
    // Even rows park the horizontal pair result; the odd row below reads it back.
    assign lb_we     = beat && col_reg[0] && !row_reg[0];

    pool_line_buf #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .widx  (lb_idx),
        .wdata (h_bit),
        .ridx  (lb_idx),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE: if (start) fsm_next = RUN;
            RUN: begin
                if (!start) begin
                    fsm_next = IDLE;
                end else if (last_beat) begin
                    fsm_next = HOLD;
                end
            end
            HOLD: if (!start) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wc_reg     <= CNT_W'(CONV_W_L1);
            col_reg    <= '0;
            row_reg    <= '0;
            pair_reg   <= 1'b0;
            dout_reg   <= 1'b0;
            ovalid_reg <= 1'b0;
            olast_reg  <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            ovalid_reg <= 1'b0;
            olast_reg  <= 1'b0;
            done_reg   <= olast_reg;
            if (!start) begin
                col_reg  <= '0;
                row_reg  <= '0;
                pair_reg <= 1'b0;
                err_reg  <= 1'b0;
            end else begin
                // Geometry is frozen for the whole frame once RUN is entered.
                if (fsm_reg == IDLE) begin
                    wc_reg <= state ? CNT_W'(CONV_W_L2) : CNT_W'(CONV_W_L1);
                end
                if (beat) begin
                    if (col_end) begin
                        col_reg <= '0;
                        row_reg <= (row_reg == wc_m1) ? '0 : row_reg + CNT_W'(1);
                    end else begin
                        col_reg <= col_reg + CNT_W'(1);
                    end
                    if (!col_reg[0]) begin
                        pair_reg <= pix_bit;
                    end else if (row_reg[0]) begin
                        dout_reg   <= lb_rd | h_bit;
                        ovalid_reg <= 1'b1;
                    end
                    olast_reg <= last_beat;
                end
                // Any up_done while still in RUN means the final beat was not
                // accepted before this cycle.
                if ((fsm_reg == RUN) && up_done) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign dout   = dout_reg;
    assign ovalid = ovalid_reg;
    assign olast  = olast_reg;
    assign done   = done_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_bin_pool2x2.sv
// -----------------------------------------------------------------------------
// tb_bin_pool2x2
// Drives whole conv frames into bin_pool2x2 and checks each pooled beat
// against a window-OR model of the frame held in the bench.
// -----------------------------------------------------------------------------
module tb_bin_pool2x2;
    import bnn_pkg::*;

    localparam logic signed [4:0] TH = 5'sd0;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       state = 1'b0;
    logic [4:0] din = '0;
    logic       ivalid = 1'b0;
    logic       up_done = 1'b0;
    logic       dout, ovalid, olast, done, err;

    bin_pool2x2 #(
        .THRESH (TH),
        .W_MAX  (26)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .state   (state),
        .din     (din),
        .ivalid  (ivalid),
        .up_done (up_done),
        .dout    (dout),
        .ovalid  (ovalid),
        .olast   (olast),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bit_v;
        logic last;
    } exp_t;

    int   vec_cnt = 0;
    int   mis_cnt = 0;
    exp_t exp_q[$];
    exp_t cur_e;
    logic got_q[$];
    logic hot_ref[$];
    logic [4:0] pix [26][26];
    int   done_cnt = 0;
    int   ov_cnt = 0;
    logic prev_olast = 1'b0;
    bit   chk_en = 1'b0;

    function automatic void check(input string name, input int act, input int req);
        vec_cnt++;
        if (act != req) begin
            mis_cnt++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    // Fill the frame and derive the pooled sequence: each output is the OR of
    // its 2x2 window after thresholding, and appears once the window's
    // bottom-right pixel (beat index) has been delivered.
    function automatic void build(input int mode, input int wc, input int nbeats);
        exp_q.delete();
        got_q.delete();
        done_cnt = 0;
        ov_cnt = 0;
        for (int r = 0; r < wc; r++) begin
            for (int c = 0; c < wc; c++) begin
                case (mode)
                    0: pix[r][c] = 5'd3;
                    1: pix[r][c] = 5'h1f;
                    2: pix[r][c] = (r == 5 && c == 8) ? 5'd0 : 5'h1e;
                    default: pix[r][c] = 5'($urandom_range(0, 31));
                endcase
            end
        end
        for (int pr = 0; pr < wc / 2; pr++) begin
            for (int pc = 0; pc < wc / 2; pc++) begin
                exp_t e;
                int   idx;
                e.bit_v = 1'b0;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        if ($signed(pix[2*pr+dr][2*pc+dc]) >= TH) e.bit_v = 1'b1;
                    end
                end
                idx = (2*pr + 1) * wc + 2*pc + 1;
                e.last = (idx == wc * wc - 1);
                if (idx < nbeats) exp_q.push_back(e);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rstn && chk_en) begin
            if (ovalid) begin
                ov_cnt++;
                got_q.push_back(dout);
                if (exp_q.size() == 0) begin
                    check("spurious_ovalid", 1, 0);
                end else begin
                    cur_e = exp_q.pop_front();
                    check("dout", int'(dout), int'(cur_e.bit_v));
                    check("olast", int'(olast), int'(cur_e.last));
                end
            end else begin
                check("olast_without_ovalid", int'(olast), 0);
            end
            check("done_after_olast", int'(done), int'(prev_olast));
            if (done) done_cnt++;
            prev_olast = olast;
        end else begin
            prev_olast = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input bit st, input int mode, input int nbeats);
        int wc;
        wc = st ? CONV_W_L2 : CONV_W_L1;
        build(mode, wc, nbeats);
        state = st;
        start = 1'b1;
        idle(1);
    endtask

    task automatic drive(input int wc, input int nbeats, input int max_gap, input bit row_gap);
        for (int i = 0; i < nbeats; i++) begin
            int r;
            int c;
            r = i / wc;
            c = i % wc;
            din = pix[r][c];
            ivalid = 1'b1;
            if (i == 3) state = ~state;
            @(posedge clk);
            #1;
            ivalid = 1'b0;
            din = 5'($urandom_range(0, 31));
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            if (row_gap && c == wc - 1) idle(2);
        end
    endtask

    task automatic full_frame(input bit st, input int mode, input int max_gap, input bit row_gap);
        int wc;
        int np;
        wc = st ? CONV_W_L2 : CONV_W_L1;
        np = (wc / 2) * (wc / 2);
        start_frame(st, mode, wc * wc);
        drive(wc, wc * wc, max_gap, row_gap);
        idle(3);
        check("frame_pulses", ov_cnt, np);
        check("queue_drained", exp_q.size(), 0);
        check("done_once", done_cnt, 1);
        check("err_clear", int'(err), 0);
        for (int k = 0; k < 6; k++) begin
            din = 5'd3;
            ivalid = 1'b1;
            @(posedge clk);
            #1;
            ivalid = 1'b0;
        end
        up_done = 1'b1;
        idle(1);
        up_done = 1'b0;
        idle(2);
        check("hold_quiet", ov_cnt, np);
        check("hold_updone_ignored", int'(err), 0);
        start = 1'b0;
        idle(2);
    endtask

    function automatic int ones(input int dummy);
        int n;
        n = dummy;
        foreach (got_q[i]) n += int'(got_q[i]);
        return n;
    endfunction

    initial begin
        int cnt;
        int ndiff;

        idle(3);
        check("rst_dout", int'(dout), 0);
        check("rst_ovalid", int'(ovalid), 0);
        check("rst_olast", int'(olast), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);

        // Hand-computed pins on the model itself.
        build(2, CONV_W_L1, CONV_W_L1 * CONV_W_L1);
        check("model_hot_size", exp_q.size(), 169);
        check("model_hot_idx30", int'(exp_q[30].bit_v), 1);
        cnt = 0;
        foreach (exp_q[i]) cnt += int'(exp_q[i].bit_v);
        check("model_hot_ones", cnt, 1);
        build(1, CONV_W_L2, CONV_W_L2 * CONV_W_L2);
        check("model_neg_size", exp_q.size(), 144);
        check("model_neg_last", int'(exp_q[143].last), 1);
        exp_q.delete();

        rstn = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // All-positive, 26x26.
        full_frame(1'b0, 0, 0, 1'b0);
        check("allpos_ones", ones(0), 169);

        // All-negative, 24x24.
        full_frame(1'b1, 1, 0, 1'b0);
        check("allneg_ones", ones(0), 0);

        // Single hot pixel (row 5, col 8) -> pooled (2, 4).
        full_frame(1'b0, 2, 0, 1'b0);
        hot_ref = got_q;
        check("hot_len", hot_ref.size(), 169);
        if (hot_ref.size() == 169) check("hot_idx30", int'(hot_ref[30]), 1);
        check("hot_ones", ones(0), 1);

        // Same stimulus with random bubbles and an inter-row gap.
        full_frame(1'b0, 2, 5, 1'b1);
        check("bubble_len", got_q.size(), hot_ref.size());
        ndiff = 0;
        foreach (got_q[i]) if (i < hot_ref.size() && got_q[i] != hot_ref[i]) ndiff++;
        check("bubble_seq_diff", ndiff, 0);

        // Random frames, both geometries.
        full_frame(1'b0, 3, 2, 1'b0);
        full_frame(1'b1, 3, 0, 1'b1);

        // Early upstream done after 100 beats.
        start_frame(1'b0, 3, 100);
        drive(CONV_W_L1, 100, 0, 1'b0);
        up_done = 1'b1;
        idle(1);
        up_done = 1'b0;
        idle(2);
        check("early_err_set", int'(err), 1);
        idle(10);
        check("early_err_sticky", int'(err), 1);
        check("early_no_done", done_cnt, 0);
        check("early_queue_drained", exp_q.size(), 0);
        start = 1'b0;
        idle(1);
        check("early_err_cleared", int'(err), 0);
        idle(2);

        // Reset mid-frame at beat 300, then a fresh 24x24 frame.
        start_frame(1'b0, 3, 300);
        drive(CONV_W_L1, 300, 0, 1'b0);
        #2;
        rstn = 1'b0;
        start = 1'b0;
        #1;
        check("mid_rst_dout", int'(dout), 0);
        check("mid_rst_ovalid", int'(ovalid), 0);
        check("mid_rst_olast", int'(olast), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_err", int'(err), 0);
        idle(3);
        check("mid_rst_ovalid_held", int'(ovalid), 0);
        exp_q.delete();
        rstn = 1'b1;
        idle(1);
        full_frame(1'b1, 3, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
